mmio_write_ctrl: RTL and testbench
==================================

# mmio_write_ctrl

Store-side counterpart of the memory-mapped read-data select path in the single-cycle ARM processor. Decodes every CPU store, steers it to data memory or to a peripheral register, and presents bomb and enemy command words to the game logic through a valid/ack handshake. Also issues the keyboard-consumed strobe and keeps sticky overrun flags that software clears through a status address.

## Interface
Parameters:
- N, 32, data word width

Ports:
- clk  input  1  processor clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- we  input  1  CPU store enable (MemWrite)
- address  input  17  CPU byte address (ALU result low bits)
- wd  input  N  CPU store data
- memWe  output  1  write enable to data memory
- bombData  output  N  last word stored to the bomb register
- bombValid  output  1  bomb command pending
- bombAck  input  1  game logic has consumed bombData
- enemyData  output  N  last word stored to the enemy register
- enemyValid  output  1  enemy command pending
- enemyAck  input  1  game logic has consumed enemyData
- kbdClear  output  1  one-cycle strobe: software consumed the keyboard word
- overrun  output  2  sticky flags; bit0 bomb, bit1 enemy

## Operation
- Address map (full 17-bit equality, no aliasing):
  - 0x100 KBD: clears the keyboard latch.
  - 0x104 BOMB: command register.
  - 0x108 ENEMY: command register.
  - 0x10C STAT: write-one-to-clear for overrun.
  - Any other address, including unaligned 0x101..0x10F, goes to memory.
- memWe = we and no MMIO address hit. Combinational.
- KBD store: kbdClear = 1 in the following cycle. wd is ignored. Back-to-back stores give back-to-back pulses.
- BOMB/ENEMY, per channel, with a valid flag V and data register D:
  - Store: D <= wd, V <= 1.
  - Ack with V = 1 and no store: V <= 0. D holds its value.
  - Ack with V = 0: ignored.
  - Store and ack in the same cycle: D <= wd, V stays 1, no overrun (the ack consumed the old word).
  - Store with V = 1 and no ack: D is overwritten, V stays 1, the channel's overrun bit is set.
- STAT store: overrun[i] <= 0 where wd[i] = 1; wd[N-1:2] are ignored. If set and clear hit the same cycle, set wins. This cannot occur from a single store and is listed for completeness.
- A store with we = 0 has no effect anywhere. Ack inputs are synchronous to clk and are not synchronised.

## Timing
- Reset (async assert, sync release by system):
  - bombData = 0, enemyData = 0.
  - bombValid = 0, enemyValid = 0.
  - kbdClear = 0, overrun = 0.
  - memWe follows its combinational equation and is 0 whenever we = 0.
- Reset asserted mid-handshake drops valid at once. Any pending command is lost; no ack is required.
- Latency:
  - memWe: 0 cycles.
  - Data, valid, kbdClear and overrun change on the rising edge that samples the store and are visible 1 cycle later.
  - Valid falls the edge after ack is sampled.
- Peripheral contract: data is stable while valid is high, unless overwritten (which flags overrun).

## Structure
- Package mmio_pkg holds:
  - localparams ADDR_KBD = 17'h100, ADDR_BOMB = 17'h104, ADDR_ENEMY = 17'h108, ADDR_STAT = 17'h10C.
  - Overrun bit indices OVR_BOMB = 0, OVR_ENEMY = 1.
- The same package is used by the read-data select so both directions share one map.
- Sub-module mmio_handshake_reg #(N) holds data, valid, the overrun-set output and the store/ack rules. It is instantiated twice (bomb, enemy).
- The top level holds the decoder, the kbdClear flop and the overrun/STAT logic.
- Total size is roughly 150-200 lines.

## Test plan
- Reset: hold reset low, toggle clk and ack inputs. Required: all outputs 0, and memWe = 0 with we = 0.
- Decode:
  - Store 0x1234 to 0x0040: memWe = 1, no valid change.
  - Store to 0x101: memWe = 1.
  - Store to 0x104: memWe = 0.
- Bomb handshake:
  - Store 0xA5 to 0x104: next cycle bombData = 0xA5, bombValid = 1.
  - Hold bombAck = 0 for 3 cycles: valid and data stable.
  - Pulse ack: valid = 0 next cycle, data still 0xA5.
- Overrun and clear:
  - Store 0x1 to 0x108, then 0x2 to 0x108 without ack: enemyData = 0x2, overrun = 2'b10.
  - Store 0x1 to 0x10C: overrun stays 2'b10.
  - Store 0x2 to 0x10C: overrun = 0.
- Simultaneous: with bombValid = 1, store 0x7 to 0x104 while bombAck = 1. Required: bombData = 0x7, bombValid = 1, overrun[0] = 0.
- Keyboard and reset: two consecutive stores to 0x100 give kbdClear high for exactly 2 cycles. Asserting reset with enemyValid = 1 drops it in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared memory-mapped I/O address map for the store path and the read-data select.
package mmio_pkg;

    localparam logic [16:0] ADDR_KBD   = 17'h100;
    localparam logic [16:0] ADDR_BOMB  = 17'h104;
    localparam logic [16:0] ADDR_ENEMY = 17'h108;
    localparam logic [16:0] ADDR_STAT  = 17'h10C;

    localparam int OVR_BOMB  = 0;
    localparam int OVR_ENEMY = 1;

    typedef enum logic [2:0] {
        HIT_NONE,
        HIT_KBD,
        HIT_BOMB,
        HIT_ENEMY,
        HIT_STAT
    } mmio_hit_t;

    // Exact 17-bit match only, so unaligned addresses near the block fall through to memory.
    function automatic mmio_hit_t mmio_decode(input logic [16:0] addr);
        mmio_hit_t hit;
        hit = HIT_NONE;
        case (addr)
            ADDR_KBD:   hit = HIT_KBD;
            ADDR_BOMB:  hit = HIT_BOMB;
            ADDR_ENEMY: hit = HIT_ENEMY;
            ADDR_STAT:  hit = HIT_STAT;
            default:    hit = HIT_NONE;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/mmio_handshake_reg.sv
// One command channel: data register plus valid flag with store/ack rules and overrun detection.
module mmio_handshake_reg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         store,
    input  logic         ack,
    input  logic [N-1:0] wd,
    output logic [N-1:0] data,
    output logic         valid,
    output logic         ovr_set
);

    // A store only overruns when the pending word was not consumed in the same cycle.
    assign ovr_set = store && valid && !ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (store) begin
            data  <= wd;
            valid <= 1'b1;
        end else if (ack) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_write_ctrl.sv
// CPU store decoder: routes stores to data memory or MMIO registers, drives command handshakes.
module mmio_write_ctrl
    import mmio_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [16:0]  address,
    input  logic [N-1:0] wd,
    output logic         memWe,
    output logic [N-1:0] bombData,
    output logic         bombValid,
    input  logic         bombAck,
    output logic [N-1:0] enemyData,
    output logic         enemyValid,
    input  logic         enemyAck,
    output logic         kbdClear,
    output logic [1:0]   overrun
);

    mmio_hit_t hit;
    logic      kbd_store;
    logic      bomb_store;
    logic      enemy_store;
    logic      stat_store;
    logic [1:0] ovr_set;
    logic [1:0] ovr_clr;

    assign hit         = mmio_decode(address);
    assign kbd_store   = we && (hit == HIT_KBD);
    assign bomb_store  = we && (hit == HIT_BOMB);
    assign enemy_store = we && (hit == HIT_ENEMY);
    assign stat_store  = we && (hit == HIT_STAT);
    assign memWe       = we && (hit == HIT_NONE);

    assign ovr_clr = stat_store ? wd[1:0] : 2'b00;

    mmio_handshake_reg #(.N(N)) u_bomb (
        .clk     (clk),
        .reset   (reset),
        .store   (bomb_store),
        .ack     (bombAck),
        .wd      (wd),
        .data    (bombData),
        .valid   (bombValid),
        .ovr_set (ovr_set[OVR_BOMB])
    );

    mmio_handshake_reg #(.N(N)) u_enemy (
        .clk     (clk),
        .reset   (reset),
        .store   (enemy_store),
        .ack     (enemyAck),
        .wd      (wd),
        .data    (enemyData),
        .valid   (enemyValid),
        .ovr_set (ovr_set[OVR_ENEMY])
    );

    // Set has priority over write-one-to-clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbdClear <= 1'b0;
            overrun  <= 2'b00;
        end else begin
            kbdClear <= kbd_store;
            overrun  <= (overrun & ~ovr_clr) | ovr_set;
        end
    end

endmodule

// File: tb/tb_mmio_write_ctrl.sv
// Directed and randomized bench for mmio_write_ctrl against a transaction-level reference model.
module tb_mmio_write_ctrl;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         we = 1'b0;
    logic [16:0]  address = '0;
    logic [N-1:0] wd = '0;
    logic         bombAck = 1'b0;
    logic         enemyAck = 1'b0;
    logic         memWe;
    logic [N-1:0] bombData;
    logic         bombValid;
    logic [N-1:0] enemyData;
    logic         enemyValid;
    logic         kbdClear;
    logic [1:0]   overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: channel 0 = bomb, channel 1 = enemy.
    logic [N-1:0] m_data [2];
    logic         m_valid[2];
    logic [1:0]   m_ovr;
    logic         m_kbd;

    mmio_write_ctrl #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .address    (address),
        .wd         (wd),
        .memWe      (memWe),
        .bombData   (bombData),
        .bombValid  (bombValid),
        .bombAck    (bombAck),
        .enemyData  (enemyData),
        .enemyValid (enemyValid),
        .enemyAck   (enemyAck),
        .kbdClear   (kbdClear),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_data[c]  = '0;
            m_valid[c] = 1'b0;
        end
        m_ovr = 2'b00;
        m_kbd = 1'b0;
    endtask

    function automatic logic model_mem_we();
        return we && !(address inside {17'h100, 17'h104, 17'h108, 17'h10C});
    endfunction

    // Apply one rising edge worth of architectural effect to the model.
    task automatic model_edge();
        logic [16:0] chan_addr[2];
        logic        acks[2];
        logic [1:0]  new_ovr;
        chan_addr[0] = 17'h104;
        chan_addr[1] = 17'h108;
        acks[0] = bombAck;
        acks[1] = enemyAck;
        new_ovr = m_ovr;
        if (we && address == 17'h10C)
            new_ovr = new_ovr & ~wd[1:0];
        for (int c = 0; c < 2; c++) begin
            if (we && address == chan_addr[c]) begin
                if (m_valid[c] && !acks[c])
                    new_ovr[c] = 1'b1;
                m_data[c]  = wd;
                m_valid[c] = 1'b1;
            end else if (acks[c]) begin
                m_valid[c] = 1'b0;
            end
        end
        m_ovr = new_ovr;
        m_kbd = we && address == 17'h100;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".bombData"},   64'(bombData),   64'(m_data[0]));
        check({ctx, ".bombValid"},  64'(bombValid),  64'(m_valid[0]));
        check({ctx, ".enemyData"},  64'(enemyData),  64'(m_data[1]));
        check({ctx, ".enemyValid"}, 64'(enemyValid), 64'(m_valid[1]));
        check({ctx, ".kbdClear"},   64'(kbdClear),   64'(m_kbd));
        check({ctx, ".overrun"},    64'(overrun),    64'(m_ovr));
    endtask

    // Called on the falling edge: drive, check combinational memWe, clock, then check registers.
    task automatic drive(input string ctx, input logic w, input logic [16:0] a,
                         input logic [N-1:0] d, input logic ba, input logic ea);
        we = w;
        address = a;
        wd = d;
        bombAck = ba;
        enemyAck = ea;
        #1;
        check({ctx, ".memWe"}, 64'(memWe), 64'(model_mem_we()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(ctx);
    endtask

    initial begin
        model_reset();

        // Reset held: outputs stay clear while clock and acks toggle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bombAck  = 1'($urandom);
            enemyAck = 1'($urandom);
            #1;
            check("rst.memWe", 64'(memWe), 64'(0));
            check_all("rst");
        end
        @(negedge clk);
        reset = 1'b1;
        bombAck = 1'b0;
        enemyAck = 1'b0;

        // Decode
        drive("dec_mem", 1'b1, 17'h0040, 32'h1234, 1'b0, 1'b0);
        check("dec_mem.noValid", 64'({bombValid, enemyValid}), 64'(0));
        drive("dec_unaligned", 1'b1, 17'h0101, 32'hDEAD, 1'b0, 1'b0);
        drive("dec_bomb", 1'b1, 17'h0104, 32'h0, 1'b0, 1'b0);
        drive("dec_ack", 1'b0, 17'h0, 32'h0, 1'b1, 1'b0);

        // Bomb handshake
        drive("bomb_st", 1'b1, 17'h0104, 32'hA5, 1'b0, 1'b0);
        check("bomb_st.data", 64'(bombData), 64'hA5);
        check("bomb_st.valid", 64'(bombValid), 64'(1));
        for (int i = 0; i < 3; i++)
            drive("bomb_hold", 1'b0, 17'h0, 32'h0, 1'b0, 1'b0);
        check("bomb_hold.data", 64'(bombData), 64'hA5);
        drive("bomb_ack", 1'b0, 17'h0, 32'h0, 1'b1, 1'b0);
        check("bomb_ack.valid", 64'(bombValid), 64'(0));
        check("bomb_ack.data", 64'(bombData), 64'hA5);
        bombAck = 1'b0;

        // Overrun and clear
        drive("enm_1", 1'b1, 17'h0108, 32'h1, 1'b0, 1'b0);
        drive("enm_2", 1'b1, 17'h0108, 32'h2, 1'b0, 1'b0);
        check("enm_2.data", 64'(enemyData), 64'h2);
        check("enm_2.ovr", 64'(overrun), 64'(2'b10));
        drive("stat_1", 1'b1, 17'h010C, 32'h1, 1'b0, 1'b0);
        check("stat_1.ovr", 64'(overrun), 64'(2'b10));
        drive("stat_2", 1'b1, 17'h010C, 32'h2, 1'b0, 1'b0);
        check("stat_2.ovr", 64'(overrun), 64'(0));

        // Store and ack together
        drive("sim_pre", 1'b1, 17'h0104, 32'h3, 1'b0, 1'b0);
        drive("sim", 1'b1, 17'h0104, 32'h7, 1'b1, 1'b0);
        check("sim.data", 64'(bombData), 64'h7);
        check("sim.valid", 64'(bombValid), 64'(1));
        check("sim.ovr0", 64'(overrun[0]), 64'(0));

        // Keyboard strobes
        drive("kbd_1", 1'b1, 17'h0100, 32'hFFFF, 1'b0, 1'b0);
        check("kbd_1.pulse", 64'(kbdClear), 64'(1));
        drive("kbd_2", 1'b1, 17'h0100, 32'h0, 1'b0, 1'b0);
        check("kbd_2.pulse", 64'(kbdClear), 64'(1));
        drive("kbd_3", 1'b0, 17'h0100, 32'h0, 1'b0, 1'b0);
        check("kbd_3.pulse", 64'(kbdClear), 64'(0));

        // Randomized traffic biased toward the MMIO window
        for (int i = 0; i < 400; i++) begin
            logic [16:0] a;
            case ($urandom_range(0, 7))
                0, 6:    a = 17'h104;
                1, 7:    a = 17'h108;
                2:       a = 17'h10C;
                3:       a = 17'h100;
                4:       a = 17'(17'h100 + $urandom_range(1, 15));
                default: a = 17'($urandom);
            endcase
            drive("rnd", 1'($urandom_range(0, 3) != 0), a, $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset with a pending enemy command
        drive("ar_pre", 1'b1, 17'h0108, 32'h55, 1'b0, 1'b0);
        check("ar_pre.valid", 64'(enemyValid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("ar.enemyValid", 64'(enemyValid), 64'(0));
        check_all("ar");
        @(negedge clk);
        reset = 1'b1;
        drive("ar_post", 1'b0, 17'h0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
